// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the two-master data RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int RD_LAT_MAX = 4;

  // Winner when both masters request while nobody owns the RAM.
  function automatic logic tie_winner(input logic fixed_prio, input logic rr_last);
    return fixed_prio ? M0 : ~rr_last;
  endfunction

endpackage

// File: rtl/ram_rd_route.sv
// Read-return pipe: tracks which master issued each RAM read and steers the
// returning word to that master after the RAM read latency.
module ram_rd_route
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic              i_push_id,
  input  logic [DATA_W-1:0] i_ram_rd_data,
  output logic              o_m0_rvalid,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic              o_m1_rvalid,
  output logic [DATA_W-1:0] o_m1_rdata
);

  // Out-of-range latencies are pinned to the supported window.
  localparam int LAT = (RD_LAT < 1) ? 1 : (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  logic [LAT-1:0] r_valid;
  logic [LAT-1:0] r_id;
  logic           w_out_valid;
  logic           w_out_id;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      // NOTE: the pipe is a handful of flops, so it is cleared outright; a real RAM array would not be.
      r_valid <= '0;
      r_id    <= '0;
    end else begin
      // NOTE: non-blocking so each stage captures its predecessor's value from before this edge.
      r_valid[0] <= i_push;
      r_id[0]    <= i_push_id;
      for (int i = 1; i < LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_id[i]    <= r_id[i-1];
      end
    end
  end

  // A return landing in a reset cycle belongs to a discarded read.
  assign w_out_valid = r_valid[LAT-1] & ~i_clr;
  assign w_out_id    = r_id[LAT-1];

  assign o_m0_rvalid = w_out_valid & (w_out_id == M0);
  assign o_m1_rvalid = w_out_valid & (w_out_id == M1);
  assign o_m0_rdata  = o_m0_rvalid ? i_ram_rd_data : '0;
  assign o_m1_rdata  = o_m1_rvalid ? i_ram_rd_data : '0;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one data RAM (byte-select write port + read port) between the core
// load/store port (M0) and the debug/DMA loader (M1), with lockable ownership.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_m0_req,
  input  logic                i_m0_we,
  input  logic [DATA_W/8-1:0] i_m0_sel,
  input  logic [ADDR_W-1:0]   i_m0_addr,
  input  logic [DATA_W-1:0]   i_m0_wdata,
  input  logic                i_m0_lock,
  output logic                o_m0_gnt,
  output logic                o_m0_rvalid,
  output logic [DATA_W-1:0]   o_m0_rdata,
  input  logic                i_m1_req,
  input  logic                i_m1_we,
  input  logic [DATA_W/8-1:0] i_m1_sel,
  input  logic [ADDR_W-1:0]   i_m1_addr,
  input  logic [DATA_W-1:0]   i_m1_wdata,
  input  logic                i_m1_lock,
  output logic                o_m1_gnt,
  output logic                o_m1_rvalid,
  output logic [DATA_W-1:0]   o_m1_rdata,
  output logic                o_ram_rd_req,
  output logic [ADDR_W-1:0]   o_ram_rd_addr,
  output logic [DATA_W/8-1:0] o_ram_wd_sel,
  output logic [ADDR_W-1:0]   o_ram_wd_addr,
  output logic [DATA_W-1:0]   o_ram_wd_data,
  input  logic [DATA_W-1:0]   i_ram_rd_data
);

  localparam int   SEL_W = DATA_W / 8;
  localparam logic FIXED = (FIXED_PRIO != 0);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic       r_rr_last;
  logic       w_rr_last_nxt;
  logic       w_gnt0;
  logic       w_gnt1;

  logic              w_sel_we;
  logic [SEL_W-1:0]  w_sel_sel;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rr_last <= M1;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_last <= w_rr_last_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves a latch behind.
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      unique case (r_state)
        IDLE: begin
          if (i_m0_req && i_m1_req) begin
            w_gnt0 = (tie_winner(FIXED, r_rr_last) == M0);
            w_gnt1 = (tie_winner(FIXED, r_rr_last) == M1);
          end else begin
            w_gnt0 = i_m0_req;
            w_gnt1 = i_m1_req;
          end
        end
        OWN0:    w_gnt0 = i_m0_req;
        OWN1:    w_gnt1 = i_m1_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rr_last_nxt = r_rr_last;
    if (w_gnt0) w_rr_last_nxt = M0;
    if (w_gnt1) w_rr_last_nxt = M1;
    unique case (r_state)
      IDLE: begin
        if (w_gnt0 && i_m0_lock)      w_state_nxt = OWN0;
        else if (w_gnt1 && i_m1_lock) w_state_nxt = OWN1;
      end
      // Owner releases either on its final unlocked beat or by dropping lock while idle.
      OWN0:    if (!i_m0_lock) w_state_nxt = IDLE;
      OWN1:    if (!i_m1_lock) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_m0_gnt = w_gnt0;
  assign o_m1_gnt = w_gnt1;

  assign w_sel_we    = w_gnt1 ? i_m1_we    : i_m0_we;
  assign w_sel_sel   = w_gnt1 ? i_m1_sel   : i_m0_sel;
  assign w_sel_addr  = w_gnt1 ? i_m1_addr  : i_m0_addr;
  assign w_sel_wdata = w_gnt1 ? i_m1_wdata : i_m0_wdata;

  always_comb begin
    o_ram_rd_req  = 1'b0;
    o_ram_rd_addr = '0;
    o_ram_wd_sel  = '0;
    o_ram_wd_addr = '0;
    o_ram_wd_data = '0;
    if (w_gnt0 || w_gnt1) begin
      if (w_sel_we) begin
        o_ram_wd_sel  = w_sel_sel;
        o_ram_wd_addr = w_sel_addr;
        o_ram_wd_data = w_sel_wdata;
      end else begin
        o_ram_rd_req  = 1'b1;
        o_ram_rd_addr = w_sel_addr;
      end
    end
  end

  ram_rd_route #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_route (
    .clk           (clk),
    .i_clr         (rst),
    .i_push        (o_ram_rd_req),
    .i_push_id     (w_gnt1 ? M1 : M0),
    .i_ram_rd_data (i_ram_rd_data),
    .o_m0_rvalid   (o_m0_rvalid),
    .o_m0_rdata    (o_m0_rdata),
    .o_m1_rvalid   (o_m1_rvalid),
    .o_m1_rdata    (o_m1_rdata)
  );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: three configurations (RR/lat1, RR/lat3, fixed/lat1),
// each with a behavioural RAM, checked cycle by cycle against an abstract model.
module tb_ram_port_arbiter;

  localparam int NDUT  = 3;
  localparam int WORDS = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] k;

  logic        req   [2];
  logic        we    [2];
  logic [3:0]  sel   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        lock  [2];

  logic        gnt0_a [NDUT];
  logic        gnt1_a [NDUT];
  logic        rv0_a  [NDUT];
  logic        rv1_a  [NDUT];
  logic [31:0] rd0_a  [NDUT];
  logic [31:0] rd1_a  [NDUT];
  logic        rrq_a  [NDUT];
  logic [31:0] rra_a  [NDUT];
  logic [3:0]  wsel_a [NDUT];
  logic [31:0] wa_a   [NDUT];
  logic [31:0] wdd_a  [NDUT];

  function automatic logic [31:0] init_word(input int g, input int i);
    return 32'((i + 1) * 32'h9E37_79B9) ^ 32'(g << 28);
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int LAT = (g == 1) ? 3 : 1;
    localparam int FP  = (g == 2) ? 1 : 0;
    logic        act;
    logic [31:0] mem  [WORDS];
    logic [31:0] pipe [LAT];
    assign act = (k == 2'(g));

    ram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(LAT), .FIXED_PRIO(FP)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .i_m0_req      (req[0] & act),
      .i_m0_we       (we[0]),
      .i_m0_sel      (sel[0]),
      .i_m0_addr     (addr[0]),
      .i_m0_wdata    (wdata[0]),
      .i_m0_lock     (lock[0]),
      .o_m0_gnt      (gnt0_a[g]),
      .o_m0_rvalid   (rv0_a[g]),
      .o_m0_rdata    (rd0_a[g]),
      .i_m1_req      (req[1] & act),
      .i_m1_we       (we[1]),
      .i_m1_sel      (sel[1]),
      .i_m1_addr     (addr[1]),
      .i_m1_wdata    (wdata[1]),
      .i_m1_lock     (lock[1]),
      .o_m1_gnt      (gnt1_a[g]),
      .o_m1_rvalid   (rv1_a[g]),
      .o_m1_rdata    (rd1_a[g]),
      .o_ram_rd_req  (rrq_a[g]),
      .o_ram_rd_addr (rra_a[g]),
      .o_ram_wd_sel  (wsel_a[g]),
      .o_ram_wd_addr (wa_a[g]),
      .o_ram_wd_data (wdd_a[g]),
      .i_ram_rd_data (pipe[LAT-1])
    );

    initial for (int i = 0; i < WORDS; i++) mem[i] <= init_word(g, i);

    always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
        if (wsel_a[g][b]) mem[wa_a[g][7:2]][8*b +: 8] <= wdd_a[g][8*b +: 8];
      pipe[0] <= mem[rra_a[g][7:2]];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  logic        ob_gnt0, ob_gnt1, ob_rv0, ob_rv1, ob_rrq;
  logic [31:0] ob_rd0, ob_rd1, ob_rra, ob_wa, ob_wd;
  logic [3:0]  ob_wsel;
  assign ob_gnt0 = gnt0_a[k];
  assign ob_gnt1 = gnt1_a[k];
  assign ob_rv0  = rv0_a[k];
  assign ob_rv1  = rv1_a[k];
  assign ob_rd0  = rd0_a[k];
  assign ob_rd1  = rd1_a[k];
  assign ob_rrq  = rrq_a[k];
  assign ob_rra  = rra_a[k];
  assign ob_wsel = wsel_a[k];
  assign ob_wa   = wa_a[k];
  assign ob_wd   = wdd_a[k];

  // Reference model state: owner (-1 = nobody), last winner, memory image, pending returns.
  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } ret_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          owner   = -1;
  int          last    = 1;
  logic [31:0] mdl_mem [WORDS];
  ret_t        rq [$];

  logic        s_gnt0, s_gnt1, s_rv0, s_rv1;
  logic [31:0] s_rd0, s_rd1;

  function automatic int lat_of(input logic [1:0] n);
    return (n == 2'd1) ? 3 : 1;
  endfunction

  function automatic bit fp_of(input logic [1:0] n);
    return (n == 2'd2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d, dut %0d)", tag, obs, expv, cyc, k);
    end
  endtask

  task automatic set_idle(input int m);
    req[m] = 1'b0; we[m] = 1'b0; sel[m] = '0; addr[m] = '0; wdata[m] = '0; lock[m] = 1'b0;
  endtask

  task automatic set_rd(input int m, input logic [31:0] a, input logic lk);
    req[m] = 1'b1; we[m] = 1'b0; sel[m] = '0; addr[m] = a; wdata[m] = '0; lock[m] = lk;
  endtask

  task automatic set_wr(input int m, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic lk);
    req[m] = 1'b1; we[m] = 1'b1; sel[m] = s; addr[m] = a; wdata[m] = d; lock[m] = lk;
  endtask

  task automatic rand_txn(input int m);
    if ($urandom_range(0, 3) == 0) begin
      set_idle(m);
    end else if ($urandom_range(0, 1) == 0) begin
      set_rd(m, {24'd0, 6'($urandom), 2'b00}, $urandom_range(0, 3) == 0);
    end else begin
      set_wr(m, {24'd0, 6'($urandom), 2'b00}, $urandom,
             ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom), $urandom_range(0, 3) == 0);
    end
  endtask

  // One clock: compare every DUT output with the model, then advance the model.
  task automatic step(output int g);
    int          eg;
    int          idx;
    ret_t        r;
    logic        e_rrq, e_rv0, e_rv1;
    logic [31:0] e_rra, e_wa, e_wd, e_rd0, e_rd1;
    logic [3:0]  e_wsel;
    @(negedge clk);
    g = -1;
    if (rst) begin
      check("rst_ctrl", {26'd0, ob_gnt0, ob_gnt1, ob_rv0, ob_rv1, ob_rrq, |ob_wsel}, 32'd0);
      check("rst_rdata", ob_rd0 | ob_rd1, 32'd0);
      check("rst_ram_bus", ob_rra | ob_wa | ob_wd, 32'd0);
      owner = -1;
      last  = 1;
      rq.delete();
    end else begin
      if (owner >= 0)              eg = req[owner] ? owner : -1;
      else if (req[0] && req[1])   eg = fp_of(k) ? 0 : 1 - last;
      else if (req[0])             eg = 0;
      else if (req[1])             eg = 1;
      else                         eg = -1;
      check("gnt", {30'd0, ob_gnt0, ob_gnt1}, {30'd0, eg == 0, eg == 1});

      e_rrq = 1'b0; e_rra = '0; e_wsel = '0; e_wa = '0; e_wd = '0;
      if (eg >= 0) begin
        if (we[eg]) begin
          e_wsel = sel[eg]; e_wa = addr[eg]; e_wd = wdata[eg];
        end else begin
          e_rrq = 1'b1; e_rra = addr[eg];
        end
      end
      check("ram_rd_req", {31'd0, ob_rrq}, {31'd0, e_rrq});
      check("ram_rd_addr", ob_rra, e_rra);
      check("ram_wd_sel", {28'd0, ob_wsel}, {28'd0, e_wsel});
      check("ram_wd_addr", ob_wa, e_wa);
      check("ram_wd_data", ob_wd, e_wd);

      e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd0 = '0; e_rd1 = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        if (r.id == 0) begin e_rv0 = 1'b1; e_rd0 = r.data; end
        else           begin e_rv1 = 1'b1; e_rd1 = r.data; end
      end
      check("rvalid", {30'd0, ob_rv0, ob_rv1}, {30'd0, e_rv0, e_rv1});
      check("m0_rdata", ob_rd0, e_rd0);
      check("m1_rdata", ob_rd1, e_rd1);

      if (eg >= 0) begin
        last = eg;
        idx  = int'(addr[eg][7:2]);
        if (we[eg]) begin
          for (int b = 0; b < 4; b++)
            if (sel[eg][b]) mdl_mem[idx][8*b +: 8] = wdata[eg][8*b +: 8];
        end else begin
          rq.push_back('{cyc + lat_of(k), eg, mdl_mem[idx]});
        end
        if (owner < 0) begin
          if (lock[eg]) owner = eg;
        end else if (!lock[eg]) begin
          owner = -1;
        end
      end else if (owner >= 0 && !lock[owner]) begin
        owner = -1;
      end
      g = eg;
    end
    s_gnt0 = ob_gnt0; s_gnt1 = ob_gnt1; s_rv0 = ob_rv0; s_rv1 = ob_rv1;
    s_rd0  = ob_rd0;  s_rd1  = ob_rd1;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic select_dut(input int n);
    int g;
    k = 2'(n);
    for (int i = 0; i < WORDS; i++) mdl_mem[i] = init_word(n, i);
    set_idle(0);
    set_idle(1);
    rst = 1'b1;
    step(g);
    step(g);
    rst = 1'b0;
  endtask

  task automatic random_phase(input int n);
    int g;
    rand_txn(0);
    rand_txn(1);
    for (int i = 0; i < n; i++) begin
      rst = (i == n / 2);
      step(g);
      rst = 1'b0;
      if (g >= 0) rand_txn(g);
      for (int m = 0; m < 2; m++) begin
        if (m == g) continue;
        if (!req[m]) begin
          if ($urandom_range(0, 1) == 0) rand_txn(m);
        end else if ($urandom_range(0, 15) == 0) begin
          set_idle(m);
        end
      end
    end
    set_idle(0);
    set_idle(1);
    for (int i = 0; i < 6; i++) step(g);
  endtask

  initial begin
    int g;
    int seen;
    rst = 1'b1;
    k   = 2'd0;
    set_idle(0);
    set_idle(1);
    for (int i = 0; i < WORDS; i++) mdl_mem[i] = init_word(0, i);
    @(posedge clk);
    #1;

    // Reset held with both masters requesting; M0 wins the first free cycle.
    set_rd(0, 32'h0, 1'b0);
    set_rd(1, 32'h4, 1'b0);
    step(g);
    step(g);
    rst = 1'b0;
    step(g);
    check("t1_first_m0", {30'd0, s_gnt0, s_gnt1}, 32'b10);
    set_rd(0, 32'h8, 1'b0);

    // Both read continuously: grants alternate starting with M1.
    for (int i = 0; i < 8; i++) begin
      step(g);
      check("t2_alternate", {30'd0, s_gnt0, s_gnt1}, (i % 2 == 0) ? 32'b01 : 32'b10);
      if (g >= 0) set_rd(g, {24'd0, 6'($urandom), 2'b00}, 1'b0);
    end
    set_idle(0);
    set_idle(1);
    step(g);
    step(g);

    // Locked write/read pair by M1 while M0 keeps requesting.
    set_rd(0, 32'h10, 1'b0);
    step(g);
    set_rd(0, 32'h14, 1'b0);
    set_wr(1, 32'h40, 32'hDEADBEEF, 4'hF, 1'b1);
    step(g);
    check("t3_wr_m0_blocked", {30'd0, s_gnt0, s_gnt1}, 32'b01);
    set_rd(1, 32'h40, 1'b0);
    step(g);
    check("t3_rd_m0_blocked", {30'd0, s_gnt0, s_gnt1}, 32'b01);
    set_idle(1);
    step(g);
    check("t3_m0_after", {31'd0, s_gnt0}, 32'd1);
    check("t3_m1_rvalid", {31'd0, s_rv1}, 32'd1);
    check("t3_m1_rdata", s_rd1, 32'hDEADBEEF);
    set_idle(0);
    step(g);

    // Partial byte write, then a sel=0 write that must leave the word alone.
    set_wr(0, 32'h20, 32'h11223344, 4'hF, 1'b0);
    step(g);
    set_wr(0, 32'h20, 32'h000000AA, 4'b0001, 1'b0);
    step(g);
    set_rd(0, 32'h20, 1'b0);
    step(g);
    set_wr(0, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b0);
    step(g);
    check("t4_byte_rvalid", {31'd0, s_rv0}, 32'd1);
    check("t4_byte_merge", s_rd0, 32'h112233AA);
    set_rd(0, 32'h20, 1'b0);
    step(g);
    set_idle(0);
    step(g);
    check("t4_sel0_no_change", s_rd0, 32'h112233AA);

    random_phase(400);

    // RD_LAT=3: three reads in flight (last one locked), then reset.
    select_dut(1);
    set_rd(0, 32'h08, 1'b0);
    step(g);
    set_rd(0, 32'h0C, 1'b0);
    step(g);
    set_rd(0, 32'h10, 1'b1);
    step(g);
    req[0] = 1'b0;
    rst = 1'b1;
    step(g);
    seen = int'(s_rv0 | s_rv1);
    rst = 1'b0;
    set_rd(1, 32'h14, 1'b0);
    step(g);
    seen += int'(s_rv0 | s_rv1);
    check("t5_lock_released", {31'd0, s_gnt1}, 32'd1);
    set_idle(1);
    lock[0] = 1'b0;
    step(g);
    seen += int'(s_rv0 | s_rv1);
    check("t5_no_rvalid", 32'(seen), 32'd0);
    for (int i = 0; i < 4; i++) step(g);

    random_phase(400);

    // Fixed priority: M0 wins every contended cycle, M1 gets the first free one.
    select_dut(2);
    set_rd(1, 32'h30, 1'b0);
    set_rd(0, 32'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(g);
      check("t6_m0_wins", {30'd0, s_gnt0, s_gnt1}, 32'b10);
      set_rd(0, {24'd0, 6'(i + 1), 2'b00}, 1'b0);
    end
    set_idle(0);
    step(g);
    check("t6_m1_next", {31'd0, s_gnt1}, 32'd1);
    set_idle(1);
    step(g);

    random_phase(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
